// File: rtl/axis_spi_pkg.sv
// Shared types and helpers for the axis_spi receive/transmit blocks.
package axis_spi_pkg;

  localparam int DROP_CNT_W = 16;

  function automatic int bytes_per_word(input int data_width, input int word_width);
    return word_width / data_width;
  endfunction

endpackage

// File: rtl/axis_spi_rx_packer_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast) with master and slave views.
interface axis_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_spi_rx_packer_sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO
// is accepted only when a pop happens in the same cycle. Shared with the TX side.
module axis_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AW + 1)'(DEPTH));
  assign empty_o = (r_count == (AW + 1)'(0));
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rd_ptr];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  // Pointer and occupancy tracking; clear wins over any same-cycle push/pop.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW + 1)'(0);
    end else if (clr_i) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW + 1)'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

endmodule

// File: rtl/axis_spi_rx_packer.sv
// Packs received SPI bytes MSB-first into words, buffers them and emits framed
// AXI-Stream words. Optional drop status via `AXIS_SPI_RX_STATUS_EN.
module axis_spi_rx_packer
  import axis_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 4
) (
  input  logic    clk_i,
  input  logic    arst_i,
  input  logic    flush_i,
  axis_if.slave   s_axis,
  axis_if.master  m_axis
`ifdef AXIS_SPI_RX_STATUS_EN
  ,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH, WORD_WIDTH);
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int FCW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  if (WORD_WIDTH < DATA_WIDTH || (WORD_WIDTH % DATA_WIDTH) != 0) begin : g_bad_width
    $error("WORD_WIDTH must be a non-zero multiple of DATA_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("FRAME_LEN must be at least 1");
  end

  logic                  r_tready;
  logic [BCW-1:0]        r_byte_cnt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [FCW-1:0]        r_frame_cnt;

  logic                  w_accept;
  logic                  w_last_byte;
  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_frame_end;
  logic                  w_full;
  logic                  w_empty;
  logic [WORD_WIDTH-1:0] w_rdata;
  logic [CW-1:0]         w_count;

  assign w_accept    = s_axis.tvalid && r_tready && !flush_i;
  assign w_last_byte = (r_byte_cnt == BCW'(BYTES - 1));
  assign w_word      = (r_shift << DATA_WIDTH) | WORD_WIDTH'(s_axis.tdata);
  assign w_push      = w_accept && w_last_byte;
  assign w_valid     = (w_count != CW'(0));
  assign w_pop       = w_valid && m_axis.tready && !flush_i;
  assign w_frame_end = (r_frame_cnt == FCW'(FRAME_LEN - 1));

  assign s_axis.tready = r_tready;
  assign m_axis.tvalid = w_valid;
  assign m_axis.tdata  = w_empty ? WORD_WIDTH'(0) : w_rdata;
  assign m_axis.tlast  = w_valid && w_frame_end;

  axis_sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .clr_i   (flush_i),
    .push_i  (w_push),
    .wdata_i (w_word),
    .full_o  (w_full),
    .pop_i   (w_pop),
    .rdata_o (w_rdata),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Byte packer; a completed word leaves the pack state empty whether or not it fits.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_tready   <= 1'b0;
      r_byte_cnt <= BCW'(0);
      r_shift    <= WORD_WIDTH'(0);
    end else begin
      r_tready <= 1'b1;
      if (flush_i) begin
        r_byte_cnt <= BCW'(0);
        r_shift    <= WORD_WIDTH'(0);
      end else if (w_accept) begin
        if (w_last_byte) begin
          r_byte_cnt <= BCW'(0);
          r_shift    <= WORD_WIDTH'(0);
        end else begin
          r_byte_cnt <= r_byte_cnt + BCW'(1);
          r_shift    <= w_word;
        end
      end
    end
  end

  // Position of the head word within its output frame.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_frame_cnt <= FCW'(0);
    end else if (flush_i) begin
      r_frame_cnt <= FCW'(0);
    end else if (w_pop) begin
      r_frame_cnt <= w_frame_end ? FCW'(0) : (r_frame_cnt + FCW'(1));
    end
  end

`ifdef AXIS_SPI_RX_STATUS_EN
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  w_drop;

  assign w_drop     = w_push && w_full && !w_pop;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

  // Sticky drop flag and saturating drop counter; flush leaves them alone.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= DROP_CNT_W'(0);
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end
`endif

endmodule
